// File: rtl/upsample_pkg.sv
// upsample_pkg: shared state encoding, pixel type and counter-width helper for the unpooling stream
package upsample_pkg;

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

    localparam int PIXEL_W = 16;
    typedef logic [PIXEL_W-1:0] pixel_t;

    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unpool_line_buffer.sv
// unpool_line_buffer: one pooled row of pixels, synchronous write, combinational read, no reset on storage
module unpool_line_buffer
    import upsample_pkg::*;
#(
    parameter int BITWIDTH = PIXEL_W,
    parameter int DEPTH    = 7,
    parameter int AW       = cw(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [BITWIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [BITWIDTH-1:0] rdata
);

    logic [BITWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/upsample_unpool_stream.sv
// upsample_unpool_stream: nearest-neighbour unpooling, buffers one pooled row then replays it KWIDTH x KHEIGHT.
// Define UNPOOL_ZERO_FILL_EN for max-unpool style output (only the top-left beat of each block carries data).
module upsample_unpool_stream
    import upsample_pkg::*;
#(
    parameter int BITWIDTH = 16,
    parameter int PWIDTH   = 7,
    parameter int PHEIGHT  = 7,
    parameter int CHANNEL  = 4,
    parameter int KWIDTH   = 4,
    parameter int KHEIGHT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int CW  = cw(PWIDTH);
    localparam int KXW = cw(KWIDTH);
    localparam int RYW = cw(KHEIGHT);
    localparam int PRW = cw(PHEIGHT);
    localparam int CHW = cw(CHANNEL);
    localparam logic [CW-1:0]  COL_MAX = CW'(PWIDTH - 1);
    localparam logic [KXW-1:0] KX_MAX  = KXW'(KWIDTH - 1);
    localparam logic [RYW-1:0] RY_MAX  = RYW'(KHEIGHT - 1);
    localparam logic [PRW-1:0] PR_MAX  = PRW'(PHEIGHT - 1);
    localparam logic [CHW-1:0] CH_MAX  = CHW'(CHANNEL - 1);

    state_t state, state_nxt;

    logic [CW-1:0]       in_col, sx, sx_n, nsx;
    logic [KXW-1:0]      kx, kx_n, nkx;
    logic [RYW-1:0]      ry, ry_n, nry;
    logic [PRW-1:0]      pr;
    logic [CHW-1:0]      ch;
    logic                acc, fill_end, fire, kx_wrap, sx_wrap, ry_wrap, row_end, last_n;
    logic [BITWIDTH-1:0] rd_data, src, pix_n;

    assign in_ready = (state == FILL);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    unpool_line_buffer #(
        .BITWIDTH(BITWIDTH),
        .DEPTH   (PWIDTH),
        .AW      (CW)
    ) u_line_buf (
        .clk  (clk),
        .we   (acc),
        .waddr(in_col),
        .wdata(in_data),
        .raddr(nsx),
        .rdata(rd_data)
    );

    // n* = coordinates of the beat to be loaded into the output register next
    always_comb begin
        acc      = (state == FILL) && in_valid;
        fill_end = acc && (in_col == COL_MAX);
        fire     = (state == EMIT) && out_valid && out_ready;
        kx_wrap  = (kx == KX_MAX);
        sx_wrap  = (sx == COL_MAX);
        ry_wrap  = (ry == RY_MAX);
        kx_n     = kx_wrap ? '0 : kx + 1'b1;
        sx_n     = kx_wrap ? (sx_wrap ? '0 : sx + 1'b1) : sx;
        ry_n     = (kx_wrap && sx_wrap) ? (ry_wrap ? '0 : ry + 1'b1) : ry;
        row_end  = fire && kx_wrap && sx_wrap && ry_wrap;
        nkx      = (state == EMIT) ? kx_n : '0;
        nsx      = (state == EMIT) ? sx_n : '0;
        nry      = (state == EMIT) ? ry_n : '0;
        last_n   = (ch == CH_MAX) && (pr == PR_MAX) && (nry == RY_MAX) && (nsx == COL_MAX) && (nkx == KX_MAX);
        // the final pixel of a row lands in the buffer on this same edge, so forward it
        src      = (acc && (in_col == nsx)) ? in_data : rd_data;
`ifdef UNPOOL_ZERO_FILL_EN
        pix_n    = ((nkx == '0) && (nry == '0)) ? src : '0;
`else
        pix_n    = src;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? FILL : IDLE;
            FILL:    state_nxt = fill_end ? EMIT : FILL;
            EMIT:    state_nxt = row_end ? (((pr == PR_MAX) && (ch == CH_MAX)) ? DONE : FILL) : EMIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col    <= '0;
            kx        <= '0;
            sx        <= '0;
            ry        <= '0;
            pr        <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (acc) in_col <= fill_end ? '0 : in_col + 1'b1;
            if (fill_end) begin
                out_valid <= 1'b1;
                out_data  <= pix_n;
                out_last  <= last_n;
            end
            if (fire) begin
                kx <= kx_n;
                sx <= sx_n;
                ry <= ry_n;
                if (row_end) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    pr        <= (pr == PR_MAX) ? '0 : pr + 1'b1;
                    if (pr == PR_MAX) ch <= (ch == CH_MAX) ? '0 : ch + 1'b1;
                end else begin
                    out_data <= pix_n;
                    out_last <= last_n;
                end
            end
        end
    end

endmodule
